// File: rtl/hack_run_ctrl.sv
// hack_run_ctrl: run/load controller for the Hack CPU and its instruction ROM.
// Streams a byte image into ROM (high byte first), then gates the CPU with
// reset and clock-enable for run, halt, single-step and a PC breakpoint.
// Optional macro CYCLE_COUNT_EN adds a 32-bit enabled-cycle counter with
// a synchronous clear input.
module hack_run_ctrl #(
  parameter int ROM_AW    = 15,
  parameter int ROM_WORDS = 32768
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_load,
  input  logic              cmd_run,
  input  logic              cmd_halt,
  input  logic              cmd_step,
  input  logic              cmd_abort,
  input  logic [7:0]        ld_data,
  input  logic              ld_valid,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic [15:0]       pc,
  input  logic [15:0]       bp_addr,
  input  logic              bp_en,
  output logic              cpu_reset,
  output logic              cpu_clk_en,
  output logic              rom_we,
  output logic [ROM_AW-1:0] rom_addr,
  output logic [15:0]       rom_wdata,
  output logic [2:0]        state,
  output logic [ROM_AW:0]   word_count
`ifdef CYCLE_COUNT_EN
  ,
  input  logic              cycle_clr,
  output logic [31:0]       cycle_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_HALT = 3'd2,
    S_RUN  = 3'd3,
    S_STEP = 3'd4
  } state_t;

  localparam logic [ROM_AW:0] WORDS_FULL = (ROM_AW+1)'(ROM_WORDS);
  localparam logic [ROM_AW:0] WORDS_LAST = (ROM_AW+1)'(ROM_WORDS - 1);

  state_t     state_reg, state_next;
  logic       phase_low_reg;   // 0: expecting high byte, 1: expecting low byte
  logic [7:0] hi_byte_reg;
  logic       bp_skip_reg;     // lets execution resume past a breakpoint

  logic ld_accept;
  logic wr_fire;
  logic load_done;
  logic load_entry;
  logic bp_hit;

  assign state      = state_reg;
  assign ld_ready   = (state_reg == S_LOAD) && (word_count < WORDS_FULL);
  assign ld_accept  = ld_valid && ld_ready;
  assign wr_fire    = ld_accept && phase_low_reg;
  // Load ends on the final byte, or on the low byte that fills the ROM.
  assign load_done  = ld_accept && (ld_last || (phase_low_reg && (word_count == WORDS_LAST)));
  assign load_entry = (state_reg != S_LOAD) && (state_next == S_LOAD);
  assign bp_hit     = bp_en && (pc == bp_addr) && !bp_skip_reg;

  // Next-state and clock-enable decode; abort beats every other command.
  always_comb begin
    state_next = state_reg;
    cpu_clk_en = 1'b0;
    case (state_reg)
      S_RUN:   cpu_clk_en = !bp_hit;
      S_STEP:  cpu_clk_en = 1'b1;
      default: cpu_clk_en = 1'b0;
    endcase
    if (cmd_abort) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (cmd_halt)      state_next = S_IDLE;
          else if (cmd_load) state_next = S_LOAD;
          else if (cmd_step) state_next = S_STEP;
          else if (cmd_run)  state_next = S_RUN;
        end
        S_LOAD: begin
          if (load_done) state_next = S_IDLE;
        end
        S_HALT: begin
          if (cmd_halt)      state_next = S_HALT;
          else if (cmd_load) state_next = S_LOAD;
          else if (cmd_step) state_next = S_STEP;
          else if (cmd_run)  state_next = S_RUN;
        end
        S_RUN: begin
          if (cmd_halt || bp_hit) state_next = S_HALT;
        end
        S_STEP: begin
          state_next = S_HALT;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  // State register, registered CPU reset and breakpoint-skip flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      cpu_reset   <= 1'b1;
      bp_skip_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cpu_reset <= (state_next == S_IDLE) || (state_next == S_LOAD);
      if ((state_reg == S_HALT) && ((state_next == S_RUN) || (state_next == S_STEP)))
        bp_skip_reg <= 1'b1;
      else if (cpu_clk_en)
        bp_skip_reg <= 1'b0;
    end
  end

  // Byte assembly and ROM write port; a write issued on the low byte
  // always completes, even if the load is aborted in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_low_reg <= 1'b0;
      hi_byte_reg   <= '0;
      rom_we        <= 1'b0;
      rom_addr      <= '0;
      rom_wdata     <= '0;
      word_count    <= '0;
    end else begin
      rom_we <= wr_fire;
      if (ld_accept && !phase_low_reg)
        hi_byte_reg <= ld_data;
      if (load_entry || (state_next != S_LOAD))
        phase_low_reg <= 1'b0;
      else if (ld_accept)
        phase_low_reg <= !phase_low_reg;
      if (load_entry) begin
        word_count <= '0;
      end else if (wr_fire) begin
        rom_addr   <= word_count[ROM_AW-1:0];
        rom_wdata  <= {hi_byte_reg, ld_data};
        word_count <= word_count + 1'b1;
      end
    end
  end

`ifdef CYCLE_COUNT_EN
  // Counts CPU-enabled cycles; clear wins over a same-cycle increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cycle_count <= '0;
    else if (cycle_clr || load_entry)
      cycle_count <= '0;
    else if (cpu_clk_en)
      cycle_count <= cycle_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_hack_run_ctrl.sv
// Directed table-driven bench for hack_run_ctrl (ROM_AW=3, ROM_WORDS=4).
// Each record holds one cycle of inputs and the outputs expected during
// that cycle; a few hand sequences cover breakpoint run-up, step, abort.
module tb_hack_run_ctrl;

  localparam int AW = 3;
  localparam int WORDS = 4;

  localparam logic [4:0] C_NONE = 5'b00000;
  localparam logic [4:0] C_RUN  = 5'b00001;
  localparam logic [4:0] C_STEP = 5'b00010;
  localparam logic [4:0] C_LOAD = 5'b00100;
  localparam logic [4:0] C_HALT = 5'b01000;
  localparam logic [4:0] C_ABT  = 5'b10000;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_load, cmd_run, cmd_halt, cmd_step, cmd_abort;
  logic [7:0]    ld_data;
  logic          ld_valid, ld_last, ld_ready;
  logic [15:0]   pc, bp_addr;
  logic          bp_en;
  logic          cpu_reset, cpu_clk_en, rom_we;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_wdata;
  logic [2:0]    state;
  logic [AW:0]   word_count;
`ifdef CYCLE_COUNT_EN
  logic          cycle_clr = 1'b0;
  logic [31:0]   cycle_count;
`endif

  hack_run_ctrl #(.ROM_AW(AW), .ROM_WORDS(WORDS)) dut (
    .clk(clk), .reset(reset),
    .cmd_load(cmd_load), .cmd_run(cmd_run), .cmd_halt(cmd_halt),
    .cmd_step(cmd_step), .cmd_abort(cmd_abort),
    .ld_data(ld_data), .ld_valid(ld_valid), .ld_last(ld_last), .ld_ready(ld_ready),
    .pc(pc), .bp_addr(bp_addr), .bp_en(bp_en),
    .cpu_reset(cpu_reset), .cpu_clk_en(cpu_clk_en),
    .rom_we(rom_we), .rom_addr(rom_addr), .rom_wdata(rom_wdata),
    .state(state), .word_count(word_count)
`ifdef CYCLE_COUNT_EN
    , .cycle_clr(cycle_clr), .cycle_count(cycle_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic [4:0]    cmd;
    logic          vld;
    logic          last;
    logic [7:0]    data;
    logic [15:0]   pcv;
    logic [2:0]    e_state;
    logic          e_rr;
    logic          e_en;
    logic          e_rdy;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [15:0]   e_wd;
    logic [AW:0]   e_wc;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  task automatic add(input logic rst, input logic [4:0] cmd, input logic vld,
                     input logic last, input logic [7:0] data, input logic [15:0] pcv,
                     input logic [2:0] st, input logic rr, input logic en,
                     input logic rdy, input logic we, input logic [AW-1:0] addr,
                     input logic [15:0] wd, input logic [AW:0] wc);
    vec_t t;
    t.rst = rst; t.cmd = cmd; t.vld = vld; t.last = last; t.data = data; t.pcv = pcv;
    t.e_state = st; t.e_rr = rr; t.e_en = en; t.e_rdy = rdy; t.e_we = we;
    t.e_addr = addr; t.e_wd = wd; t.e_wc = wc;
    vecs.push_back(t);
  endtask

  task automatic check1(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic check_outputs(input string name, input vec_t t);
    logic [28:0] got, exp;
    got = {state, cpu_reset, cpu_clk_en, ld_ready, rom_we, rom_addr, rom_wdata, word_count};
    exp = {t.e_state, t.e_rr, t.e_en, t.e_rdy, t.e_we, t.e_addr, t.e_wd, t.e_wc};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got st=%0d rr=%b en=%b rdy=%b we=%b a=%0h d=%h wc=%0d expected st=%0d rr=%b en=%b rdy=%b we=%b a=%0h d=%h wc=%0d",
               name, state, cpu_reset, cpu_clk_en, ld_ready, rom_we, rom_addr, rom_wdata, word_count,
               t.e_state, t.e_rr, t.e_en, t.e_rdy, t.e_we, t.e_addr, t.e_wd, t.e_wc);
    end
  endtask

  task automatic drive(input vec_t t);
    reset     = t.rst;
    cmd_abort = t.cmd[4];
    cmd_halt  = t.cmd[3];
    cmd_load  = t.cmd[2];
    cmd_step  = t.cmd[1];
    cmd_run   = t.cmd[0];
    ld_valid  = t.vld;
    ld_last   = t.last;
    ld_data   = t.data;
    pc        = t.pcv;
  endtask

  task automatic idle_inputs();
    cmd_load = 0; cmd_run = 0; cmd_halt = 0; cmd_step = 0; cmd_abort = 0;
    ld_valid = 0; ld_last = 0; ld_data = 0;
  endtask

  initial begin
    vec_t rv;
    bit   hit;
    reset = 1'b1; idle_inputs(); pc = 0; bp_en = 1'b1; bp_addr = 16'd3;

    // 1: four-byte load, two words
    add(0,C_LOAD,0,0,8'h00,0, 0,1,0,0,0,0,16'h0000,0);
    add(0,C_NONE,1,0,8'h00,0, 1,1,0,1,0,0,16'h0000,0);
    add(0,C_NONE,1,0,8'h05,0, 1,1,0,1,0,0,16'h0000,0);
    add(0,C_NONE,1,0,8'hEC,0, 1,1,0,1,1,0,16'h0005,1);
    add(0,C_NONE,1,1,8'h10,0, 1,1,0,1,0,0,16'h0005,1);
    add(0,C_NONE,0,0,8'h00,0, 0,1,0,0,1,1,16'hEC10,2);
    add(0,C_NONE,0,0,8'h00,0, 0,1,0,0,0,1,16'hEC10,2);
    // 2: odd byte count, trailing high byte discarded
    add(0,C_LOAD,0,0,8'h00,0, 0,1,0,0,0,1,16'hEC10,2);
    add(0,C_NONE,1,0,8'h12,0, 1,1,0,1,0,1,16'hEC10,0);
    add(0,C_NONE,1,0,8'h34,0, 1,1,0,1,0,1,16'hEC10,0);
    add(0,C_NONE,1,1,8'h56,0, 1,1,0,1,1,0,16'h1234,1);
    add(0,C_NONE,0,0,8'h00,0, 0,1,0,0,0,0,16'h1234,1);
    // 3: capacity, ten bytes offered, four words written
    add(0,C_LOAD,0,0,8'h00,0, 0,1,0,0,0,0,16'h1234,1);
    add(0,C_NONE,1,0,8'h01,0, 1,1,0,1,0,0,16'h1234,0);
    add(0,C_NONE,1,0,8'h02,0, 1,1,0,1,0,0,16'h1234,0);
    add(0,C_NONE,1,0,8'h03,0, 1,1,0,1,1,0,16'h0102,1);
    add(0,C_NONE,1,0,8'h04,0, 1,1,0,1,0,0,16'h0102,1);
    add(0,C_NONE,1,0,8'h05,0, 1,1,0,1,1,1,16'h0304,2);
    add(0,C_NONE,1,0,8'h06,0, 1,1,0,1,0,1,16'h0304,2);
    add(0,C_NONE,1,0,8'h07,0, 1,1,0,1,1,2,16'h0506,3);
    add(0,C_NONE,1,0,8'h08,0, 1,1,0,1,0,2,16'h0506,3);
    add(0,C_NONE,1,0,8'h09,0, 0,1,0,0,1,3,16'h0708,4);
    add(0,C_NONE,1,1,8'h0A,0, 0,1,0,0,0,3,16'h0708,4);
    add(0,C_NONE,0,0,8'h00,0, 0,1,0,0,0,3,16'h0708,4);
    // 4: breakpoint at 3, then resume past it
    add(0,C_RUN, 0,0,8'h00,0, 0,1,0,0,0,3,16'h0708,4);
    add(0,C_NONE,0,0,8'h00,0, 3,0,1,0,0,3,16'h0708,4);
    add(0,C_NONE,0,0,8'h00,1, 3,0,1,0,0,3,16'h0708,4);
    add(0,C_NONE,0,0,8'h00,2, 3,0,1,0,0,3,16'h0708,4);
    add(0,C_NONE,0,0,8'h00,3, 3,0,0,0,0,3,16'h0708,4);
    add(0,C_RUN, 0,0,8'h00,3, 2,0,0,0,0,3,16'h0708,4);
    add(0,C_NONE,0,0,8'h00,3, 3,0,1,0,0,3,16'h0708,4);
    add(0,C_NONE,0,0,8'h00,4, 3,0,1,0,0,3,16'h0708,4);
    add(0,C_NONE,0,0,8'h00,5, 3,0,1,0,0,3,16'h0708,4);
    add(0,C_HALT,0,0,8'h00,6, 3,0,1,0,0,3,16'h0708,4);
    add(0,C_NONE,0,0,8'h00,7, 2,0,0,0,0,3,16'h0708,4);
    // 5: single step, then halt+step together while running
    add(0,C_STEP,0,0,8'h00,7, 2,0,0,0,0,3,16'h0708,4);
    add(0,C_NONE,0,0,8'h00,7, 4,0,1,0,0,3,16'h0708,4);
    add(0,C_NONE,0,0,8'h00,8, 2,0,0,0,0,3,16'h0708,4);
    add(0,C_NONE,0,0,8'h00,8, 2,0,0,0,0,3,16'h0708,4);
    add(0,C_RUN, 0,0,8'h00,8, 2,0,0,0,0,3,16'h0708,4);
    add(0,C_NONE,0,0,8'h00,8, 3,0,1,0,0,3,16'h0708,4);
    add(0,C_HALT|C_STEP,0,0,8'h00,9, 3,0,1,0,0,3,16'h0708,4);
    add(0,C_NONE,0,0,8'h00,10, 2,0,0,0,0,3,16'h0708,4);
    add(0,C_NONE,0,0,8'h00,10, 2,0,0,0,0,3,16'h0708,4);
    // 6: abort while running, reset mid-load, abort with write in flight
    add(0,C_RUN, 0,0,8'h00,10, 2,0,0,0,0,3,16'h0708,4);
    add(0,C_NONE,0,0,8'h00,10, 3,0,1,0,0,3,16'h0708,4);
    add(0,C_ABT, 0,0,8'h00,11, 3,0,1,0,0,3,16'h0708,4);
    add(0,C_NONE,0,0,8'h00,11, 0,1,0,0,0,3,16'h0708,4);
    add(0,C_LOAD,0,0,8'h00,0, 0,1,0,0,0,3,16'h0708,4);
    add(0,C_NONE,1,0,8'hAA,0, 1,1,0,1,0,3,16'h0708,0);
    add(1,C_NONE,1,0,8'hBB,0, 0,1,0,0,0,0,16'h0000,0);
    add(0,C_NONE,1,0,8'hBB,0, 0,1,0,0,0,0,16'h0000,0);
    add(0,C_NONE,0,0,8'h00,0, 0,1,0,0,0,0,16'h0000,0);
    add(0,C_LOAD,0,0,8'h00,0, 0,1,0,0,0,0,16'h0000,0);
    add(0,C_NONE,1,0,8'h11,0, 1,1,0,1,0,0,16'h0000,0);
    add(0,C_NONE,1,0,8'h22,0, 1,1,0,1,0,0,16'h0000,0);
    add(0,C_ABT, 1,0,8'h33,0, 1,1,0,1,1,0,16'h1122,1);
    add(0,C_NONE,0,0,8'h00,0, 0,1,0,0,0,0,16'h1122,1);

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    rv.e_state = 0; rv.e_rr = 1; rv.e_en = 0; rv.e_rdy = 0; rv.e_we = 0;
    rv.e_addr = 0; rv.e_wd = 0; rv.e_wc = 0;
    check_outputs("reset_values", rv);
    $display("reset: st=%0d rr=%b en=%b rdy=%b", state, cpu_reset, cpu_clk_en, ld_ready);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      drive(vecs[i]);
      @(negedge clk);
      check_outputs($sformatf("vec%0d", i), vecs[i]);
      $display("vec %0d: cmd=%b vld=%b d=%h pc=%0d -> st=%0d rr=%b en=%b rdy=%b we=%b a=%0h d=%h wc=%0d",
               i, vecs[i].cmd, vecs[i].vld, vecs[i].data, vecs[i].pcv, state, cpu_reset,
               cpu_clk_en, ld_ready, rom_we, rom_addr, rom_wdata, word_count);
    end

    // Hand sequence: run from IDLE with a modelled PC until breakpoint at 5.
    @(posedge clk); #1;
    reset = 0; idle_inputs(); bp_addr = 16'd5; pc = 0; cmd_run = 1;
    @(posedge clk); #1;
    cmd_run = 0;
    hit = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!cpu_clk_en) begin
        hit = 1;
        break;
      end
      @(posedge clk); #1;
      pc = pc + 16'd1;
    end
    check1("bp_hit_seen", {31'd0, hit}, 32'd1);
    check1("bp_hit_pc", {16'd0, pc}, 32'd5);
    $display("bp run: stopped=%b pc=%0d", hit, pc);
    @(posedge clk); #1;
    @(negedge clk);
    check1("bp_halt_state", {29'd0, state}, 32'd2);

    // Step at the breakpoint address executes regardless of the compare.
    @(posedge clk); #1; cmd_step = 1;
    @(posedge clk); #1; cmd_step = 0;
    @(negedge clk);
    check1("step_en", {31'd0, cpu_clk_en}, 32'd1);
    check1("step_state", {29'd0, state}, 32'd4);
    @(posedge clk); #1; pc = 16'd6;
    @(negedge clk);
    check1("step_done_state", {29'd0, state}, 32'd2);
    check1("step_done_en", {31'd0, cpu_clk_en}, 32'd0);
    $display("step: st=%0d en=%b", state, cpu_clk_en);

    // Abort from HALT returns to IDLE with the CPU held in reset.
    @(posedge clk); #1; cmd_abort = 1;
    @(posedge clk); #1; cmd_abort = 0;
    @(negedge clk);
    check1("abort_halt_state", {29'd0, state}, 32'd0);
    check1("abort_halt_rr", {31'd0, cpu_reset}, 32'd1);
    $display("abort: st=%0d rr=%b", state, cpu_reset);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
